// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: arbitrates I-cache reads, D-cache reads and D-cache write-backs onto one memory port.
// Define ARB_RR_EN for round-robin grants (dcw -> dcr -> ic); the default is fixed priority dcw > dcr > ic.
module mem_req_arbiter #(
    parameter int RD_BEATS = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         icr_start_rq,
    input  logic [31:0]  ic_rin_addr,
    input  logic         dcr_start_rq,
    input  logic [31:0]  dcr_rin_addr,
    input  logic         dcw_start_rq,
    input  logic [31:0]  dcw_in_addr,
    input  logic [15:0]  dcw_in_mask,
    input  logic [127:0] dcw_in_data,
    output logic         mem_rq_valid,
    input  logic         mem_rq_ready,
    output logic         mem_rq_we,
    output logic [31:0]  mem_rq_addr,
    output logic [15:0]  mem_rq_mask,
    output logic [127:0] mem_rq_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_rvalid,
    input  logic         mem_wresp,
    output logic [127:0] ic_rdat_m_data,
    output logic         ic_rdat_m_valid,
    output logic         ic_finish_mrd,
    output logic [127:0] rdat_m_data,
    output logic         rdat_m_valid,
    output logic         finish_mrd,
    output logic         dcw_finish_wresp,
    output logic         arb_busy
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2, WAIT_WR = 2'd3;
    localparam logic [1:0] G_IC = 2'd0, G_DR = 2'd1, G_DW = 2'd2;
    logic [1:0]   state, grant, sel, cnt;
    logic         pend_ic, pend_dr, pend_dw;
    logic [2:0]   pend;
    logic [31:0]  ic_addr, dr_addr, dw_addr;
    logic [15:0]  dw_mask;
    logic [127:0] dw_data;
    logic         issue, hs, beat, last_beat;
    logic         clr_ic, clr_dr, clr_dw, acc_ic, acc_dr, acc_dw;
    assign pend      = {pend_dw, pend_dr, pend_ic};
    assign issue     = state == ISSUE;
    assign hs        = issue && mem_rq_ready;
    assign beat      = state == WAIT_RD && mem_rvalid;
    assign last_beat = beat && cnt == 2'(RD_BEATS - 1);
    assign clr_ic    = hs && grant == G_IC;
    assign clr_dr    = hs && grant == G_DR;
    assign clr_dw    = hs && grant == G_DW;
    // a pulse on the handshake cycle of its own grant is accepted, since that bit clears now
    assign acc_ic    = icr_start_rq && (!pend_ic || clr_ic);
    assign acc_dr    = dcr_start_rq && (!pend_dr || clr_dr);
    assign acc_dw    = dcw_start_rq && (!pend_dw || clr_dw);
`ifdef ARB_RR_EN
    logic [1:0] last, o0, o1;
    function automatic logic [1:0] nxt(input logic [1:0] g);
        return g == G_IC ? G_DW : g == G_DW ? G_DR : G_IC;
    endfunction
    assign o0  = nxt(last);
    assign o1  = nxt(o0);
    assign sel = pend[o0] ? o0 : pend[o1] ? o1 : last;
`else
    assign sel = pend[G_DW] ? G_DW : pend[G_DR] ? G_DR : G_IC;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {pend_ic, pend_dr, pend_dw} <= '0;
            {ic_addr, dr_addr, dw_addr} <= '0;
            dw_mask <= '0;
            dw_data <= '0;
        end else begin
            if (acc_ic) begin
                pend_ic <= 1'b1;
                ic_addr <= ic_rin_addr;
            end else if (clr_ic) pend_ic <= 1'b0;
            if (acc_dr) begin
                pend_dr <= 1'b1;
                dr_addr <= dcr_rin_addr;
            end else if (clr_dr) pend_dr <= 1'b0;
            if (acc_dw) begin
                pend_dw <= 1'b1;
                dw_addr <= dcw_in_addr;
                dw_mask <= dcw_in_mask;
                dw_data <= dcw_in_data;
            end else if (clr_dw) pend_dw <= 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= G_IC;
            cnt   <= '0;
`ifdef ARB_RR_EN
            last  <= G_IC;
`endif
        end else begin
            case (state)
                IDLE: if (|pend) begin
                    grant <= sel;
                    state <= ISSUE;
`ifdef ARB_RR_EN
                    last  <= sel;
`endif
                end
                ISSUE:   if (mem_rq_ready) state <= grant == G_DW ? WAIT_WR : WAIT_RD;
                WAIT_RD: if (mem_rvalid) begin
                    cnt   <= last_beat ? 2'd0 : cnt + 2'd1;
                    state <= last_beat ? IDLE : WAIT_RD;
                end
                default: if (mem_wresp) state <= IDLE;
            endcase
        end
    end
    assign mem_rq_valid     = issue;
    assign mem_rq_we        = issue && grant == G_DW;
    assign mem_rq_addr      = !issue ? 32'd0 : grant == G_DW ? dw_addr : grant == G_DR ? dr_addr : ic_addr;
    assign mem_rq_mask      = mem_rq_we ? dw_mask : 16'd0;
    assign mem_rq_wdata     = mem_rq_we ? dw_data : 128'd0;
    assign ic_rdat_m_valid  = beat && grant == G_IC;
    assign ic_rdat_m_data   = ic_rdat_m_valid ? mem_rdata : 128'd0;
    assign ic_finish_mrd    = last_beat && grant == G_IC;
    assign rdat_m_valid     = beat && grant == G_DR;
    assign rdat_m_data      = rdat_m_valid ? mem_rdata : 128'd0;
    assign finish_mrd       = last_beat && grant == G_DR;
    assign dcw_finish_wresp = state == WAIT_WR && mem_wresp;
    assign arb_busy         = state != IDLE;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scoreboard bench for mem_req_arbiter with 4-beat line fills.
module tb_mem_req_arbiter;
    localparam int RDB = 4;
    logic         clk = 1'b0, rst_n = 1'b0;
    logic         icr_start_rq = 0, dcr_start_rq = 0, dcw_start_rq = 0;
    logic [31:0]  ic_rin_addr = 0, dcr_rin_addr = 0, dcw_in_addr = 0;
    logic [15:0]  dcw_in_mask = 0;
    logic [127:0] dcw_in_data = 0, mem_rdata = 0;
    logic         mem_rq_ready = 0, mem_rvalid = 0, mem_wresp = 0;
    logic         mem_rq_valid, mem_rq_we;
    logic [31:0]  mem_rq_addr;
    logic [15:0]  mem_rq_mask;
    logic [127:0] mem_rq_wdata, ic_rdat_m_data, rdat_m_data;
    logic         ic_rdat_m_valid, ic_finish_mrd, rdat_m_valid, finish_mrd, dcw_finish_wresp, arb_busy;
    int tests = 0, fails = 0;
    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [15:0]  mask;
        logic [127:0] wdata;
    } req_t;
    req_t exp_q[$];

    mem_req_arbiter #(.RD_BEATS(RDB)) dut (
        .clk(clk), .rst_n(rst_n),
        .icr_start_rq(icr_start_rq), .ic_rin_addr(ic_rin_addr),
        .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr),
        .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr),
        .dcw_in_mask(dcw_in_mask), .dcw_in_data(dcw_in_data),
        .mem_rq_valid(mem_rq_valid), .mem_rq_ready(mem_rq_ready), .mem_rq_we(mem_rq_we),
        .mem_rq_addr(mem_rq_addr), .mem_rq_mask(mem_rq_mask), .mem_rq_wdata(mem_rq_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_wresp(mem_wresp),
        .ic_rdat_m_data(ic_rdat_m_data), .ic_rdat_m_valid(ic_rdat_m_valid), .ic_finish_mrd(ic_finish_mrd),
        .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
        .dcw_finish_wresp(dcw_finish_wresp), .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic we, input logic [31:0] a, input logic [15:0] m, input logic [127:0] d);
        exp_q.push_back('{we, a, m, d});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rq_valid"}, mem_rq_valid, 0);
        chk({tag, "_rq_we"}, mem_rq_we, 0);
        chk({tag, "_rq_addr"}, mem_rq_addr, 0);
        chk({tag, "_rq_mask"}, mem_rq_mask, 0);
        chk({tag, "_rq_wdata"}, mem_rq_wdata, 0);
        chk({tag, "_ic_data"}, ic_rdat_m_data, 0);
        chk({tag, "_ic_valid"}, ic_rdat_m_valid, 0);
        chk({tag, "_ic_finish"}, ic_finish_mrd, 0);
        chk({tag, "_dr_data"}, rdat_m_data, 0);
        chk({tag, "_dr_valid"}, rdat_m_valid, 0);
        chk({tag, "_dr_finish"}, finish_mrd, 0);
        chk({tag, "_wresp"}, dcw_finish_wresp, 0);
        chk({tag, "_busy"}, arb_busy, 0);
    endtask

    task automatic pulse(input logic i, input logic r, input logic w);
        icr_start_rq = i;
        dcr_start_rq = r;
        dcw_start_rq = w;
        @(negedge clk);
        #1;
        {icr_start_rq, dcr_start_rq, dcw_start_rq} = '0;
    endtask

    task automatic expect_issue(input int delay);
        int   n = 0;
        req_t r;
        while (!mem_rq_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rq_valid_seen", mem_rq_valid, 1);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_underflow: observed request addr %0h expected none", mem_rq_addr);
            return;
        end
        r = exp_q.pop_front();
        for (int i = 0; i <= delay; i++) begin
            chk("rq_valid_hold", mem_rq_valid, 1);
            chk("rq_we", mem_rq_we, r.we);
            chk("rq_addr", mem_rq_addr, r.addr);
            chk("rq_mask", mem_rq_mask, r.mask);
            chk("rq_wdata", mem_rq_wdata, r.wdata);
            mem_rq_ready = (i == delay);
            @(negedge clk);
            #1;
        end
        mem_rq_ready = 0;
    endtask

    task automatic rd_beats(input logic to_ic, input int n, input int total);
        logic [127:0] d;
        for (int k = 0; k < n; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            mem_rdata = d;
            mem_rvalid = 1;
            #1;
            chk("ic_valid", ic_rdat_m_valid, to_ic);
            chk("ic_data", ic_rdat_m_data, to_ic ? d : 128'd0);
            chk("ic_finish", ic_finish_mrd, to_ic && k == total - 1);
            chk("dr_valid", rdat_m_valid, !to_ic);
            chk("dr_data", rdat_m_data, !to_ic ? d : 128'd0);
            chk("dr_finish", finish_mrd, !to_ic && k == total - 1);
            @(negedge clk);
            mem_rvalid = 0;
            #1;
        end
    endtask

    task automatic wr_resp();
        mem_wresp = 1;
        #1;
        chk("wresp_pulse", dcw_finish_wresp, 1);
        chk("wresp_no_rd", rdat_m_valid | ic_rdat_m_valid, 0);
        @(negedge clk);
        mem_wresp = 0;
        #1;
        chk("wresp_one_cycle", dcw_finish_wresp, 0);
    endtask

    initial begin
        #6;
        mem_rvalid = 1;
        mem_wresp = 1;
        mem_rdata = '1;
        chk_zero("reset");
        mem_rvalid = 0;
        mem_wresp = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        // simultaneous requests from all three
        ic_rin_addr = 32'h0000_3000;
        dcr_rin_addr = 32'h0000_4000;
        dcw_in_addr = 32'h0000_5000;
        dcw_in_mask = 16'h00F0;
        dcw_in_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
        push_req(1, 32'h0000_5000, 16'h00F0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
        push_req(0, 32'h0000_4000, 0, 0);
        push_req(0, 32'h0000_3000, 0, 0);
        pulse(1, 1, 1);
        expect_issue(0);
        mem_rvalid = 1;
        #1;
        chk("rvalid_in_wr_dr", rdat_m_valid, 0);
        chk("rvalid_in_wr_ic", ic_rdat_m_valid, 0);
        mem_rvalid = 0;
        wr_resp();
        chk("idle_after_wr", arb_busy, 0);
        expect_issue(0);
        mem_wresp = 1;
        #1;
        chk("wresp_in_rd", dcw_finish_wresp, 0);
        mem_wresp = 0;
        rd_beats(0, RDB, RDB);
        expect_issue(0);
        rd_beats(1, RDB, RDB);
        chk("idle_after_ic", arb_busy, 0);
        // ic and dcw become pending while a dcr is in flight
        dcr_rin_addr = 32'h0000_6000;
        push_req(0, 32'h0000_6000, 0, 0);
        pulse(0, 1, 0);
        expect_issue(0);
        ic_rin_addr = 32'h0000_7000;
        dcw_in_addr = 32'h0000_8000;
        dcw_in_mask = 16'h000F;
        dcw_in_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        pulse(1, 0, 1);
`ifdef ARB_RR_EN
        push_req(0, 32'h0000_7000, 0, 0);
        push_req(1, 32'h0000_8000, 16'h000F, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
`else
        push_req(1, 32'h0000_8000, 16'h000F, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        push_req(0, 32'h0000_7000, 0, 0);
`endif
        rd_beats(0, RDB, RDB);
        expect_issue(0);
`ifdef ARB_RR_EN
        rd_beats(1, RDB, RDB);
        expect_issue(0);
        wr_resp();
`else
        wr_resp();
        expect_issue(0);
        rd_beats(1, RDB, RDB);
`endif
        // write-back with a slow memory
        dcw_in_addr = 32'h0000_1000;
        dcw_in_mask = 16'hFFFF;
        dcw_in_data = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
        push_req(1, 32'h0000_1000, 16'hFFFF, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555);
        pulse(0, 0, 1);
        expect_issue(3);
        chk("wr_busy", arb_busy, 1);
        wr_resp();
        chk("wr_idle", arb_busy, 0);
        // dcr line fill
        dcr_rin_addr = 32'h0000_2000;
        push_req(0, 32'h0000_2000, 0, 0);
        pulse(0, 1, 0);
        expect_issue(0);
        rd_beats(0, RDB, RDB);
        chk("dr_idle", arb_busy, 0);
        // duplicate icr while pending is dropped; a new one during WAIT_RD is kept
        ic_rin_addr = 32'h0000_9000;
        push_req(0, 32'h0000_9000, 0, 0);
        pulse(1, 0, 0);
        ic_rin_addr = 32'h0000_A000;
        pulse(1, 0, 0);
        expect_issue(2);
        ic_rin_addr = 32'h0000_B000;
        push_req(0, 32'h0000_B000, 0, 0);
        pulse(1, 0, 0);
        rd_beats(1, RDB, RDB);
        expect_issue(0);
        rd_beats(1, RDB, RDB);
        // reset in the middle of a line fill
        dcr_rin_addr = 32'h0000_C000;
        push_req(0, 32'h0000_C000, 0, 0);
        pulse(0, 1, 0);
        expect_issue(0);
        rd_beats(0, 1, RDB);
        mem_rdata = '1;
        mem_rvalid = 1;
        rst_n = 0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("late_dr_valid", rdat_m_valid, 0);
            chk("late_dr_finish", finish_mrd, 0);
            chk("late_busy", arb_busy, 0);
            @(negedge clk);
        end
        mem_rvalid = 0;
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
